trigger_stages: RTL and testbench

//   Parametrised multi-stage trigger unit for the logic-analyzer core.

---
 rtl/trigger_stages.sv | 193 +++++++++++++++++++
 tb/tb_trigger_stages.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_stages.sv
// Multi-stage trigger unit: per-stage mask/value matching (parallel or
// serial), trigger levels, start stages and a post-match strobe delay.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not armed, no matching
// ARMED | matching active stages on each strobe; level advances on hits
// DELAY | start stage hit, counting strobes down to the trigger
// FIRED | trigger issued; holds until arm_i or disarm_i
module trigger_stages #(
   parameter int WIDTH   = 32,
   parameter int STAGES  = 4,
   parameter int DELAY_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             cfg_we_i,
   input  logic [2:0]       cfg_stage_i,
   input  logic [1:0]       cfg_sel_i,
   input  logic [31:0]      cfg_data_i,
   input  logic             arm_i,
   input  logic             disarm_i,
   input  logic             stb_i,
   input  logic [WIDTH-1:0] smpls_i,
   output logic             armed_o,
   output logic [1:0]       level_o,
   output logic             run_o,
   output logic             fired_o
);

   typedef enum logic [1:0] {IDLE, ARMED, DELAY, FIRED} state_t;

   logic [WIDTH-1:0]   mask   [STAGES];
   logic [WIDTH-1:0]   value  [STAGES];
   logic [DELAY_W-1:0] dly    [STAGES];
   logic [1:0]         lvl    [STAGES];
   logic [4:0]         chan   [STAGES];
   logic               serial [STAGES];
   logic               start  [STAGES];
   logic [WIDTH-1:0]   sh     [STAGES];
   logic [WIDTH-1:0]   sh_nx  [STAGES];
   logic               tap    [STAGES];

   state_t             state, state_d;
   logic [1:0]         level, level_d;
   logic [DELAY_W-1:0] count, count_d;
   logic               run, run_d;
   logic               fired, fired_d;

   logic               any_hit, start_hit;
   logic [DELAY_W-1:0] start_dly;

   // Register file: stage index beyond STAGES and the reserved selector are dropped.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         for (int s = 0; s < STAGES; s++) begin
            mask[s]   <= '0;
            value[s]  <= '0;
            dly[s]    <= '0;
            lvl[s]    <= '0;
            chan[s]   <= '0;
            serial[s] <= 1'b0;
            start[s]  <= 1'b0;
         end
      end else if (cfg_we_i) begin
         for (int s = 0; s < STAGES; s++) begin
            if (cfg_stage_i == 3'(s)) begin
               case (cfg_sel_i)
                  2'd0: mask[s]  <= cfg_data_i[WIDTH-1:0];
                  2'd1: value[s] <= cfg_data_i[WIDTH-1:0];
                  2'd2: begin
                     dly[s]    <= cfg_data_i[DELAY_W-1:0];
                     lvl[s]    <= cfg_data_i[17:16];
                     chan[s]   <= cfg_data_i[24:20];
                     serial[s] <= cfg_data_i[26];
                     start[s]  <= cfg_data_i[27];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Serial tap selection and next shift value; out-of-range channels feed 0.
   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         tap[s] = 1'b0;
         for (int b = 0; b < WIDTH; b++) begin
            if (chan[s] == 5'(b)) tap[s] = smpls_i[b];
         end
         sh_nx[s] = WIDTH'({sh[s], tap[s]});
      end
   end

   // Shift registers run on every strobe regardless of FSM state.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         for (int s = 0; s < STAGES; s++) sh[s] <= '0;
      end else if (stb_i) begin
         for (int s = 0; s < STAGES; s++) sh[s] <= sh_nx[s];
      end
   end

   // Stage matching; the lowest-indexed start hit supplies the delay.
   always_comb begin
      any_hit   = 1'b0;
      start_hit = 1'b0;
      start_dly = '0;
      for (int s = 0; s < STAGES; s++) begin
         if (state == ARMED && stb_i && lvl[s] == level &&
             ((((serial[s] ? sh_nx[s] : smpls_i) ^ value[s]) & mask[s]) == '0)) begin
            any_hit = 1'b1;
            if (start[s] && !start_hit) begin
               start_hit = 1'b1;
               start_dly = dly[s];
            end
         end
      end
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
         level <= '0;
         count <= '0;
         run   <= 1'b0;
         fired <= 1'b0;
      end else begin
         state <= state_d;
         level <= level_d;
         count <= count_d;
         run   <= run_d;
         fired <= fired_d;
      end
   end

   // Next-state logic: disarm beats arm, arm beats normal progression.
   always_comb begin
      state_d = state;
      level_d = level;
      count_d = count;
      run_d   = 1'b0;
      fired_d = fired;
      if (disarm_i) begin
         state_d = IDLE;
         count_d = '0;
         fired_d = 1'b0;
      end else if (arm_i) begin
         state_d = ARMED;
         level_d = '0;
         count_d = '0;
         fired_d = 1'b0;
      end else begin
         case (state)
            ARMED: begin
               if (start_hit) begin
                  if (start_dly == '0) begin
                     state_d = FIRED;
                     run_d   = 1'b1;
                     fired_d = 1'b1;
                  end else begin
                     state_d = DELAY;
                     count_d = start_dly;
                  end
               end else if (any_hit && level != 2'd3) begin
                  level_d = level + 2'd1;
               end
            end
            DELAY: begin
               if (stb_i) begin
                  if (count == DELAY_W'(1)) begin
                     state_d = FIRED;
                     count_d = '0;
                     run_d   = 1'b1;
                     fired_d = 1'b1;
                  end else begin
                     count_d = count - DELAY_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign armed_o = (state == ARMED) || (state == DELAY);
   assign level_o = level;
   assign run_o   = run;
   assign fired_o = fired;

endmodule

// File: tb/tb_trigger_stages.sv
// Directed bench for trigger_stages with default parameters (32/4/16).
module tb_trigger_stages;

   logic        clk_i = 1'b0;
   logic        rst_in = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic [2:0]  cfg_stage_i = '0;
   logic [1:0]  cfg_sel_i = '0;
   logic [31:0] cfg_data_i = '0;
   logic        arm_i = 1'b0;
   logic        disarm_i = 1'b0;
   logic        stb_i = 1'b0;
   logic [31:0] smpls_i = '0;
   logic        armed_o;
   logic [1:0]  level_o;
   logic        run_o;
   logic        fired_o;

   int total = 0;
   int bad   = 0;

   trigger_stages dut (
      .clk_i(clk_i), .rst_in(rst_in), .cfg_we_i(cfg_we_i),
      .cfg_stage_i(cfg_stage_i), .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
      .arm_i(arm_i), .disarm_i(disarm_i), .stb_i(stb_i), .smpls_i(smpls_i),
      .armed_o(armed_o), .level_o(level_o), .run_o(run_o), .fired_o(fired_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b0; cfg_we_i = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; stb_i = 1'b0;
      tick();
      tick();
      rst_in = 1'b1;
   endtask

   task automatic wr(input logic [2:0] st, input logic [1:0] sel, input logic [31:0] d);
      cfg_we_i = 1'b1; cfg_stage_i = st; cfg_sel_i = sel; cfg_data_i = d;
      tick();
      cfg_we_i = 1'b0;
   endtask

   // Stage that only listens at level 3 and wants an all-ones sample.
   task automatic park(input logic [2:0] st);
      wr(st, 2'd0, 32'hFFFF_FFFF);
      wr(st, 2'd1, 32'hFFFF_FFFF);
      wr(st, 2'd2, 32'h0003_0000);
   endtask

   task automatic arm();
      arm_i = 1'b1; tick(); arm_i = 1'b0;
   endtask

   task automatic strobe(input logic [31:0] s);
      stb_i = 1'b1; smpls_i = s; tick(); stb_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      #2;
      total++; if (armed_o !== 1'b0) begin bad++; $display("FAIL reset_armed got=%0b exp=0", armed_o); end
      total++; if (level_o !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_o); end
      total++; if (run_o !== 1'b0)   begin bad++; $display("FAIL reset_run got=%0b exp=0", run_o); end
      total++; if (fired_o !== 1'b0) begin bad++; $display("FAIL reset_fired got=%0b exp=0", fired_o); end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      wr(3'd0, 2'd2, 32'h0800_0000);
      arm();
      total++; if (armed_o !== 1'b1) begin bad++; $display("FAIL single_armed got=%0b exp=1", armed_o); end
      total++; if (run_o !== 1'b0)   begin bad++; $display("FAIL single_run_pre got=%0b exp=0", run_o); end
      strobe(32'h1234_5678);
      total++; if (run_o !== 1'b1)   begin bad++; $display("FAIL single_run got=%0b exp=1", run_o); end
      total++; if (fired_o !== 1'b1) begin bad++; $display("FAIL single_fired got=%0b exp=1", fired_o); end
      total++; if (armed_o !== 1'b0) begin bad++; $display("FAIL single_armed_post got=%0b exp=0", armed_o); end
      tick();
      total++; if (run_o !== 1'b0)   begin bad++; $display("FAIL single_run_width got=%0b exp=0", run_o); end
      total++; if (fired_o !== 1'b1) begin bad++; $display("FAIL single_fired_sticky got=%0b exp=1", fired_o); end
   endtask

   task automatic test_levels();
      do_reset();
      park(3'd2); park(3'd3);
      wr(3'd0, 2'd0, 32'h0000_00FF);
      wr(3'd0, 2'd1, 32'h0000_00A5);
      wr(3'd1, 2'd0, 32'h0000_00FF);
      wr(3'd1, 2'd1, 32'h0000_003C);
      wr(3'd1, 2'd2, 32'h0801_0003);
      arm();
      strobe(32'h0000_005A);
      total++; if (level_o !== 2'd0) begin bad++; $display("FAIL lvl_nomatch got=%0d exp=0", level_o); end
      strobe(32'hFFFF_FFA5);
      total++; if (level_o !== 2'd1) begin bad++; $display("FAIL lvl_step got=%0d exp=1", level_o); end
      strobe(32'h0000_00A5);
      total++; if (level_o !== 2'd1) begin bad++; $display("FAIL lvl_stage0_inactive got=%0d exp=1", level_o); end
      strobe(32'h0000_003C);
      total++; if (armed_o !== 1'b1 || run_o !== 1'b0) begin bad++; $display("FAIL lvl_delay_enter got armed=%0b run=%0b exp armed=1 run=0", armed_o, run_o); end
      strobe(32'h0);
      tick();
      strobe(32'h0);
      total++; if (run_o !== 1'b0) begin bad++; $display("FAIL lvl_delay_early got=%0b exp=0", run_o); end
      strobe(32'h0);
      total++; if (run_o !== 1'b1 || fired_o !== 1'b1) begin bad++; $display("FAIL lvl_delay_fire got run=%0b fired=%0b exp 1 1", run_o, fired_o); end
      tick();
      total++; if (run_o !== 1'b0) begin bad++; $display("FAIL lvl_run_width got=%0b exp=0", run_o); end
   endtask

   task automatic test_saturate();
      do_reset();
      wr(3'd1, 2'd2, 32'h0001_0000);
      wr(3'd2, 2'd2, 32'h0002_0000);
      wr(3'd3, 2'd2, 32'h0003_0000);
      arm();
      tick();
      total++; if (level_o !== 2'd0) begin bad++; $display("FAIL sat_nostb got=%0d exp=0", level_o); end
      for (int i = 0; i < 5; i++) strobe(32'h0);
      total++; if (level_o !== 2'd3) begin bad++; $display("FAIL sat_level got=%0d exp=3", level_o); end
      total++; if (armed_o !== 1'b1 || run_o !== 1'b0) begin bad++; $display("FAIL sat_state got armed=%0b run=%0b exp 1 0", armed_o, run_o); end
   endtask

   task automatic test_serial();
      logic [3:0] bits;
      do_reset();
      park(3'd1); park(3'd2); park(3'd3);
      wr(3'd0, 2'd0, 32'h0000_000F);
      wr(3'd0, 2'd1, 32'h0000_000B);
      wr(3'd0, 2'd2, 32'h0C20_0000);
      arm();
      bits = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
         strobe(bits[i] ? 32'hFFFF_FFFF : 32'hFFFF_FFFB);
         if (i != 0) begin
            total++; if (run_o !== 1'b0) begin bad++; $display("FAIL serial_early step=%0d got=%0b exp=0", 3 - i, run_o); end
         end
      end
      total++; if (run_o !== 1'b1) begin bad++; $display("FAIL serial_fire got=%0b exp=1", run_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      park(3'd1); park(3'd2); park(3'd3);
      wr(3'd0, 2'd2, 32'h0800_0005);
      arm();
      strobe(32'h0);
      total++; if (armed_o !== 1'b1) begin bad++; $display("FAIL both_in_delay got=%0b exp=1", armed_o); end
      arm_i = 1'b1; disarm_i = 1'b1; tick(); arm_i = 1'b0; disarm_i = 1'b0;
      total++; if (armed_o !== 1'b0) begin bad++; $display("FAIL both_armed got=%0b exp=0", armed_o); end
      for (int i = 0; i < 7; i++) begin
         strobe(32'h0);
         total++; if (run_o !== 1'b0 || fired_o !== 1'b0) begin bad++; $display("FAIL both_norun i=%0d run=%0b fired=%0b exp 0 0", i, run_o, fired_o); end
      end
   endtask

   task automatic test_bad_stage();
      do_reset();
      park(3'd1); park(3'd2); park(3'd3);
      wr(3'd0, 2'd0, 32'h0000_00FF);
      wr(3'd0, 2'd1, 32'h0000_0011);
      wr(3'd0, 2'd2, 32'h0800_0000);
      wr(3'd7, 2'd0, 32'h0000_0000);
      wr(3'd7, 2'd2, 32'h0800_0000);
      wr(3'd0, 2'd3, 32'h0000_0000);
      arm();
      strobe(32'h0000_0000);
      total++; if (run_o !== 1'b0 || armed_o !== 1'b1) begin bad++; $display("FAIL badstage_ignored run=%0b armed=%0b exp 0 1", run_o, armed_o); end
      total++; if (level_o !== 2'd0) begin bad++; $display("FAIL badstage_level got=%0d exp=0", level_o); end
      strobe(32'h0000_0011);
      total++; if (run_o !== 1'b1) begin bad++; $display("FAIL badstage_match got=%0b exp=1", run_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      park(3'd1); park(3'd2); park(3'd3);
      wr(3'd0, 2'd2, 32'h0800_0004);
      arm();
      strobe(32'h0);
      #2 rst_in = 1'b0;
      #1;
      total++; if (armed_o !== 1'b0 || level_o !== 2'd0 || run_o !== 1'b0 || fired_o !== 1'b0)
         begin bad++; $display("FAIL midreset_async armed=%0b level=%0d run=%0b fired=%0b exp all 0", armed_o, level_o, run_o, fired_o); end
      #2 rst_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         strobe(32'h0);
         total++; if (run_o !== 1'b0 || armed_o !== 1'b0) begin bad++; $display("FAIL midreset_quiet i=%0d run=%0b armed=%0b exp 0 0", i, run_o, armed_o); end
      end
      arm();
      strobe(32'h0);
      total++; if (level_o !== 2'd1 || run_o !== 1'b0 || armed_o !== 1'b1)
         begin bad++; $display("FAIL midreset_cfglost level=%0d run=%0b armed=%0b exp 1 0 1", level_o, run_o, armed_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_levels();
      test_saturate();
      test_serial();
      test_back_to_back();
      test_bad_stage();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
